// File: rtl/jimmy_prog_loader_if.sv
// Byte-stream load channel for jimmy_prog_loader.
// The source drives data/valid, and the loader drives ready.
interface jimmy_prog_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/jimmy_prog_loader.sv
// Program-memory controller for the Jimmy CPU. It loads a length-prefixed image into a 256-byte store,
// then releases the CPU from reset. Defining JIMMY_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module jimmy_prog_loader #(
  parameter int DEPTH        = 256,
  parameter int CPU_RST_HOLD = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  jimmy_prog_loader_if.slave rx,
  input  logic [7:0]         inst_address_bus,
  output logic [7:0]         inst_data_bus,
  output logic               cpu_reset_n,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int HW = (CPU_RST_HOLD < 2) ? 1 : $clog2(CPU_RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(CPU_RST_HOLD);

  // HOLD is the terminal sub-step entered when the image completes before the hold counter expires
  typedef enum logic [2:0] {LEN, DATA, CSUM, HOLD, RUN, ERR} state_e;

  state_e        state_q;
  logic [8:0]    cnt_q;
  logic [7:0]    addr_q;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          cpu_reset_n_q;
  logic          busy_q;
  logic          done_q;
  logic          xfer;
  logic          load_end;
  logic          hold_ok;
  logic [7:0]    mem [DEPTH];

  assign rx.rx_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign xfer        = rx.rx_valid && rx.rx_ready;
  assign hold_d      = (hold_q == '0) ? hold_q : hold_q - HW'(1);
  assign hold_ok     = (hold_d == '0);

`ifdef JIMMY_LOADER_CHECKSUM_EN
  logic [7:0] acc_q;
  logic [7:0] acc_d;
  logic       error_q;
  logic       csum_bad;

  assign acc_d    = acc_q + rx.rx_data;
  assign load_end = (state_q == CSUM) && xfer && (acc_d == 8'd0);
  assign csum_bad = (state_q == CSUM) && xfer && (acc_d != 8'd0);
  assign error    = error_q;
`else
  assign load_end = (state_q == DATA) && xfer && (cnt_q == 9'd1);
  assign error    = 1'b0;
`endif

  assign cpu_reset_n   = cpu_reset_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign inst_data_bus = mem[inst_address_bus];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= LEN;
      hold_q        <= HOLD_INIT;
      addr_q        <= '0;
      cnt_q         <= '0;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
`ifdef JIMMY_LOADER_CHECKSUM_EN
      acc_q         <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      hold_q <= hold_d;
      case (state_q)
        LEN: if (xfer) begin
          cnt_q   <= (rx.rx_data == 8'd0) ? 9'd256 : {1'b0, rx.rx_data};
          addr_q  <= '0;
`ifdef JIMMY_LOADER_CHECKSUM_EN
          acc_q   <= '0;
`endif
          state_q <= DATA;
        end
        DATA: if (xfer) begin
          addr_q <= addr_q + 8'd1;
          cnt_q  <= cnt_q - 9'd1;
`ifdef JIMMY_LOADER_CHECKSUM_EN
          acc_q  <= acc_d;
          if (cnt_q == 9'd1) state_q <= CSUM;
`endif
        end
        RUN, ERR: if (load_req) begin
          state_q       <= LEN;
          hold_q        <= HOLD_INIT;
          cpu_reset_n_q <= 1'b0;
          busy_q        <= 1'b1;
          done_q        <= 1'b0;
`ifdef JIMMY_LOADER_CHECKSUM_EN
          error_q       <= 1'b0;
`endif
        end
        default: ;
      endcase
`ifdef JIMMY_LOADER_CHECKSUM_EN
      if (csum_bad) begin
        state_q <= ERR;
        busy_q  <= 1'b0;
        error_q <= 1'b1;
      end
`endif
      // Release only once the hold counter reaches zero on this edge
      if (load_end || (state_q == HOLD)) begin
        if (hold_ok) begin
          state_q       <= RUN;
          cpu_reset_n_q <= 1'b1;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
        end else begin
          state_q <= HOLD;
        end
      end
    end
  end

  // Memory has no reset, so a reset-aborted load keeps its earlier words
  always_ff @(posedge clk) begin
    if (reset && (state_q == DATA) && xfer) mem[addr_q] <= rx.rx_data;
  end

endmodule

// File: tb/tb_jimmy_prog_loader.sv
// Randomized scoreboard bench for jimmy_prog_loader. Expected memory contents, byte counts and release cycles
// come from a byte-level model of the image format.
module tb_jimmy_prog_loader;

  localparam int HOLD = 4;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    bit is_error;
    int nbytes;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic       rd_probe;
  logic [7:0] inst_address_bus;
  logic [7:0] inst_data_bus;
  logic       cpu_reset_n;
  logic       busy;
  logic       done;
  logic       error;

  jimmy_prog_loader_if rx();

  jimmy_prog_loader #(.DEPTH(256), .CPU_RST_HOLD(HOLD)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_req         (load_req),
    .rx               (rx),
    .inst_address_bus (inst_address_bus),
    .inst_data_bus    (inst_data_bus),
    .cpu_reset_n      (cpu_reset_n),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         entry_cyc = 0;
  bit         in_len;
  logic [7:0] mem_m [256];
  bit         known [256];
  exp_t       exp_q [$];
  logic [7:0] rd_q [$];
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;
  int         mon_nb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops read and completion expectations when the DUT presents them
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_probe) begin
        if (rd_q.size() == 0) checkOutput("read_unexpected", 1, 0);
        else checkOutput("read_data", inst_data_bus, rd_q.pop_front());
      end
      if ((done && !prev_done) || (error && !prev_err)) begin
        if (exp_q.size() == 0) begin
          checkOutput("event_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("event_error_flag", error, e.is_error);
          checkOutput("event_cpu_reset_n", cpu_reset_n, !e.is_error);
          checkOutput("event_byte_count", mon_nb, e.nbytes);
          checkOutput("event_cycle", cyc, e.cyc);
        end
        mon_nb = 0;
      end
      prev_done = done;
      prev_err  = error;
      if (!reset) mon_nb = 0;
      else if (rx.rx_valid && rx.rx_ready) mon_nb++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic doReset();
    reset       = 1'b0;
    rx.rx_valid = 1'b0;
    load_req    = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    entry_cyc = cyc;
    reset     = 1'b1;
    in_len    = 1'b1;
  endtask

  task automatic startLoad();
    if (!in_len) begin
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req  = 1'b0;
      entry_cyc = cyc;
      checkOutput("reload_cpu_reset_n", cpu_reset_n, 0);
      checkOutput("reload_rx_ready", rx.rx_ready, 1);
      checkOutput("reload_error_clear", error, 0);
      in_len = 1'b1;
    end
  endtask

  task automatic sendBytes(input byte_q_t data, input int gap_pct, output int last_cyc);
    int t;
    last_cyc = -1;
    for (int i = 0; i < data.size(); i++) begin
      rx.rx_data = data[i];
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
        rx.rx_valid = 1'b0;
        @(posedge clk); #1;
      end
      rx.rx_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!rx.rx_ready && t < 50) begin @(negedge clk); t++; end
      if (!rx.rx_ready) begin
        checkOutput("ready_timeout", 0, 1);
        rx.rx_valid = 1'b0;
        return;
      end
      last_cyc = cyc + 1;
      @(posedge clk); #1;
    end
    rx.rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input byte_q_t payload, input int cs_force, input int gap_pct);
    byte_q_t    img;
    int         sum;
    int         last;
    int         t;
    bit         bad;
    logic [7:0] cs;
    exp_t       e;
    startLoad();
    sum = 0;
    bad = 1'b0;
    img.push_back(8'(payload.size()));
    for (int i = 0; i < payload.size(); i++) begin
      img.push_back(payload[i]);
      sum += int'(payload[i]);
    end
`ifdef JIMMY_LOADER_CHECKSUM_EN
    cs = 8'((256 - (sum % 256)) % 256);
    if (cs_force >= 0) begin
      bad = (8'(cs_force) != cs);
      cs  = 8'(cs_force);
    end
    img.push_back(cs);
`else
    cs = 8'(cs_force);
`endif
    sendBytes(img, gap_pct, last);
    if (gap_pct == 0) checkOutput("throughput_last_cycle", last, entry_cyc + img.size());
    for (int k = 0; k < payload.size(); k++) begin
      mem_m[k] = payload[k];
      known[k] = 1'b1;
    end
    e.is_error = bad;
    e.nbytes   = img.size();
    e.cyc      = bad ? last : ((last > entry_cyc + HOLD) ? last : entry_cyc + HOLD);
    exp_q.push_back(e);
    in_len = 1'b0;
    t = 0;
    while (!(done || error) && t < 2 * HOLD + 10) begin @(posedge clk); #1; t++; end
    if (!(done || error)) checkOutput("release_timeout", 0, 1);
    @(posedge clk); #1;
    checkOutput("ready_low_after_load", rx.rx_ready, 0);
  endtask

  task automatic readCheck(input int lo, input int hi);
    for (int a = lo; a <= hi && a < 256; a++) begin
      if (known[a]) begin
        inst_address_bus = 8'(a);
        rd_q.push_back(mem_m[a]);
        rd_probe = 1'b1;
        @(posedge clk); #1;
      end
    end
    rd_probe = 1'b0;
  endtask

  initial begin : stimulus
    byte_q_t    pay;
    logic [7:0] p2;
    int         n;
    int         last;
    reset            = 1'b0;
    load_req         = 1'b0;
    rd_probe         = 1'b0;
    inst_address_bus = 8'd0;
    rx.rx_valid      = 1'b0;
    rx.rx_data       = 8'd0;
    in_len           = 1'b1;
    #1;
    doReset();
    checkOutput("rst_cpu_reset_n", cpu_reset_n, 0);
    checkOutput("rst_rx_ready", rx.rx_ready, 1);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);

    pay = '{8'h80, 8'h05, 8'h1C};
    applyStimulus(pay, -1, 0);
    checkOutput("basic_done", done, 1);
    inst_address_bus = 8'd1;
    #1;
    checkOutput("basic_addr1", inst_data_bus, 8'h05);
    readCheck(0, 2);

    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i));
    applyStimulus(pay, -1, 0);
    inst_address_bus = 8'hFF;
    #1;
    checkOutput("full_mem255", inst_data_bus, 8'hFF);
    readCheck(0, 255);

    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'($urandom_range(255)));
    applyStimulus(pay, -1, 50);
    readCheck(0, 7);

    pay = '{8'($urandom_range(255))};
    applyStimulus(pay, -1, 0);
    readCheck(0, 1);

`ifdef JIMMY_LOADER_CHECKSUM_EN
    pay = '{8'h10, 8'h20};
    applyStimulus(pay, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("csum_fail_error", error, 1);
    checkOutput("csum_fail_cpu_reset_n", cpu_reset_n, 0);
    readCheck(0, 1);
`endif

    pay.delete();
    for (int i = 0; i < 6; i++) pay.push_back(8'($urandom_range(255)));
    applyStimulus(pay, -1, 0);

    // Reload, then abort with reset on the edge that would take the third data byte
    startLoad();
    pay.delete();
    pay.push_back(8'd4);
    for (int i = 0; i < 2; i++) pay.push_back(mem_m[i] ^ 8'($urandom_range(1, 255)));
    p2 = mem_m[2] ^ 8'($urandom_range(1, 255));
    sendBytes(pay, 0, last);
    rx.rx_data  = p2;
    rx.rx_valid = 1'b1;
    reset       = 1'b0;
    @(posedge clk); #1;
    entry_cyc   = cyc;
    reset       = 1'b1;
    rx.rx_valid = 1'b0;
    in_len      = 1'b1;
    mem_m[0]    = pay[1];
    mem_m[1]    = pay[2];
    checkOutput("abort_rx_ready", rx.rx_ready, 1);
    checkOutput("abort_busy", busy, 1);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_cpu_reset_n", cpu_reset_n, 0);
    readCheck(0, 5);

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 24);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(255)));
      applyStimulus(pay, ($urandom_range(3) == 0) ? int'($urandom_range(255)) : -1, $urandom_range(0, 60));
      readCheck(0, n + 2);
    end

    repeat (5) begin @(posedge clk); #1; end
    checkOutput("pending_events", exp_q.size(), 0);
    checkOutput("pending_reads", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
